// File: rtl/sys_cmd_decoder.sv
// sys_cmd_decoder: command-frame controller between the RX byte synchronizer,
// the register file, the ALU and the TX path. Decodes write/read/ALU frames
// and returns read data or ALU results as bytes through a busy handshake.
// Optional build macro: CMD_TIMEOUT_EN (inter-byte timeout on partial frames).
module sys_cmd_decoder #(
  parameter int unsigned D_WIDTH     = 8,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned FUN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [D_WIDTH-1:0]     RX_P_DATA,
  input  logic                   RX_D_VLD,
  output logic                   WrEn,
  output logic                   RdEn,
  output logic [ADDR_W-1:0]      Address,
  output logic [D_WIDTH-1:0]     WrData,
  input  logic [D_WIDTH-1:0]     RdData,
  input  logic                   RdData_Valid,
  output logic                   ALU_EN,
  output logic [FUN_W-1:0]       ALU_FUN,
  output logic                   CLK_GATE_EN,
  input  logic [2*D_WIDTH-1:0]   ALU_OUT,
  input  logic                   ALU_OUT_VLD,
  output logic [D_WIDTH-1:0]     TX_P_DATA,
  output logic                   TX_D_VLD,
  input  logic                   TX_BUSY,
  output logic                   CMD_ERR
);

  localparam logic [D_WIDTH-1:0] CMD_WR     = D_WIDTH'(8'hAA);
  localparam logic [D_WIDTH-1:0] CMD_RD     = D_WIDTH'(8'hBB);
  localparam logic [D_WIDTH-1:0] CMD_ALU_OP = D_WIDTH'(8'hCC);
  localparam logic [D_WIDTH-1:0] CMD_ALU    = D_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
    S_OPA, S_OPB, S_ALU_FN, S_ALU_WAIT, S_TX_SEND, S_TX_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic                   wren_q, wren_d;
  logic                   rden_q, rden_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [D_WIDTH-1:0]     wrdata_q, wrdata_d;
  logic                   alu_en_q, alu_en_d;
  logic [FUN_W-1:0]       alu_fun_q, alu_fun_d;
  logic                   cg_q, cg_d;
  logic [D_WIDTH-1:0]     tx_data_q, tx_data_d;
  logic                   tx_vld_q, tx_vld_d;
  logic                   err_q, err_d;
  logic [2*D_WIDTH-1:0]   res_q, res_d;
  logic                   hi_sel_q, hi_sel_d;
  logic                   two_q, two_d;
  logic                   busy_seen_q, busy_seen_d;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]       cnt_q, cnt_d;
`endif

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      wren_q      <= 1'b0;
      rden_q      <= 1'b0;
      addr_q      <= '0;
      wrdata_q    <= '0;
      alu_en_q    <= 1'b0;
      alu_fun_q   <= '0;
      cg_q        <= 1'b0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      err_q       <= 1'b0;
      res_q       <= '0;
      hi_sel_q    <= 1'b0;
      two_q       <= 1'b0;
      busy_seen_q <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wren_q      <= wren_d;
      rden_q      <= rden_d;
      addr_q      <= addr_d;
      wrdata_q    <= wrdata_d;
      alu_en_q    <= alu_en_d;
      alu_fun_q   <= alu_fun_d;
      cg_q        <= cg_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      err_q       <= err_d;
      res_q       <= res_d;
      hi_sel_q    <= hi_sel_d;
      two_q       <= two_d;
      busy_seen_q <= busy_seen_d;
`ifdef CMD_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Frame decode: next state plus next value of every registered output.
  always_comb begin
    state_d     = state_q;
    wren_d      = 1'b0;
    rden_d      = 1'b0;
    alu_en_d    = 1'b0;
    tx_vld_d    = 1'b0;
    err_d       = 1'b0;
    addr_d      = addr_q;
    wrdata_d    = wrdata_q;
    alu_fun_d   = alu_fun_q;
    cg_d        = cg_q;
    tx_data_d   = tx_data_q;
    res_d       = res_q;
    hi_sel_d    = hi_sel_q;
    two_d       = two_q;
    busy_seen_d = busy_seen_q;

    unique case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR) begin
            state_d = S_WR_ADDR;
          end else if (RX_P_DATA == CMD_RD) begin
            state_d = S_RD_ADDR;
          end else if (RX_P_DATA == CMD_ALU_OP) begin
            state_d = S_OPA;
            cg_d    = 1'b1;
          end else if (RX_P_DATA == CMD_ALU) begin
            state_d = S_ALU_FN;
            cg_d    = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          rden_d  = 1'b1;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        err_d = RX_D_VLD;
        if (RdData_Valid) begin
          res_d    = {{D_WIDTH{1'b0}}, RdData};
          two_d    = 1'b0;
          hi_sel_d = 1'b0;
          state_d  = S_TX_SEND;
        end
      end
      S_OPA: begin
        if (RX_D_VLD) begin
          addr_d   = '0;
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
          state_d  = S_OPB;
        end
      end
      S_OPB: begin
        if (RX_D_VLD) begin
          addr_d   = ADDR_W'(1);
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
          state_d  = S_ALU_FN;
        end
      end
      S_ALU_FN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[FUN_W-1:0];
          alu_en_d  = 1'b1;
          state_d   = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        err_d = RX_D_VLD;
        if (ALU_OUT_VLD) begin
          res_d    = ALU_OUT;
          two_d    = 1'b1;
          hi_sel_d = 1'b0;
          cg_d     = 1'b0;
          state_d  = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        err_d = RX_D_VLD;
        if (!TX_BUSY) begin
          tx_data_d   = hi_sel_q ? res_q[2*D_WIDTH-1:D_WIDTH] : res_q[D_WIDTH-1:0];
          tx_vld_d    = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        err_d = RX_D_VLD;
        if (TX_BUSY) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          if (two_q && !hi_sel_q) begin
            hi_sel_d = 1'b1;
            state_d  = S_TX_SEND;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef CMD_TIMEOUT_EN
    // Timeout overrides the case result: abandon the partial frame.
    cnt_d = '0;
    if (state_q inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OPA, S_OPB, S_ALU_FN}) begin
      if (RX_D_VLD) begin
        cnt_d = '0;
      end else if (cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
        cg_d    = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TMO_W'(1);
      end
    end
`endif
  end

  assign WrEn        = wren_q;
  assign RdEn        = rden_q;
  assign Address     = addr_q;
  assign WrData      = wrdata_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = cg_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign CMD_ERR     = err_q;

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Directed bench for sys_cmd_decoder: per-cycle vector table with
// hand-computed outputs, plus sequences for the partial-frame behaviour.
module tb_sys_cmd_decoder;

  localparam int unsigned TMO = 255;

  logic        CLK, RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic        WrEn, RdEn;
  logic [3:0]  Address;
  logic [7:0]  WrData;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY;
  logic        CMD_ERR;

  int checks = 0;
  int errors = 0;

  sys_cmd_decoder #(.D_WIDTH(8), .ADDR_W(4), .FUN_W(4), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, rxv;
    logic [7:0]  rxd;
    logic        rdv;
    logic [7:0]  rdd;
    logic        av;
    logic [15:0] ao;
    logic        busy;
    logic [29:0] exp;
  } vec_t;

  vec_t vq[$];

  // Expected word: {WrEn,RdEn,Address,WrData,ALU_EN,ALU_FUN,CLK_GATE_EN,TX_D_VLD,TX_P_DATA,CMD_ERR}
  function automatic logic [29:0] outs();
    return {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_D_VLD, TX_P_DATA, CMD_ERR};
  endfunction

  function automatic void add(input logic rst, rxv, input logic [7:0] rxd,
                              input logic rdv, input logic [7:0] rdd,
                              input logic av, input logic [15:0] ao, input logic busy,
                              input logic we, re, input logic [3:0] ad, input logic [7:0] wd,
                              input logic ae, input logic [3:0] af, input logic cg, tv,
                              input logic [7:0] td, input logic er);
    vec_t v;
    v.rst = rst; v.rxv = rxv; v.rxd = rxd; v.rdv = rdv; v.rdd = rdd;
    v.av = av; v.ao = ao; v.busy = busy;
    v.exp = {we, re, ad, wd, ae, af, cg, tv, td, er};
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [29:0] act, input logic [29:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rxv, input logic [7:0] rxd);
    RST = 1'b0; RX_D_VLD = rxv; RX_P_DATA = rxd;
    RdData_Valid = 1'b0; RdData = '0; ALU_OUT_VLD = 1'b0; ALU_OUT = '0; TX_BUSY = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    logic seen_err;
    RST = 1'b1; RX_D_VLD = 1'b0; RX_P_DATA = '0; RdData = '0; RdData_Valid = 1'b0;
    ALU_OUT = '0; ALU_OUT_VLD = 1'b0; TX_BUSY = 1'b0;

    //   rst rxv rxd  rdv rdd  av ao      bsy  we re ad  wd    ae af  cg tv td    er
    add(1, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    // write frame AA,05,3C
    add(0, 1, 8'hAA, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 8'h05, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 5, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 8'h3C, 0, 8'h00, 0, 16'h0000, 0,  1, 0, 5, 8'h3C, 0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 5, 8'h3C, 0, 0, 0, 0, 8'h00, 0);
    // read frame BB,05 -> 3C returned
    add(0, 1, 8'hBB, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 5, 8'h3C, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 8'h05, 0, 8'h00, 0, 16'h0000, 0,  0, 1, 5, 8'h3C, 0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 5, 8'h3C, 0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 1, 8'h3C, 0, 16'h0000, 0,  0, 0, 5, 8'h3C, 0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 5, 8'h3C, 0, 0, 0, 1, 8'h3C, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 5, 8'h3C, 0, 0, 0, 0, 8'h3C, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 5, 8'h3C, 0, 0, 0, 0, 8'h3C, 0);
    // operand frame CC,07,03,00 -> 000A sent as 0A, 00
    add(0, 1, 8'hCC, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 5, 8'h3C, 0, 0, 1, 0, 8'h3C, 0);
    add(0, 1, 8'h07, 0, 8'h00, 0, 16'h0000, 0,  1, 0, 0, 8'h07, 0, 0, 1, 0, 8'h3C, 0);
    add(0, 1, 8'h03, 0, 8'h00, 0, 16'h0000, 0,  1, 0, 1, 8'h03, 0, 0, 1, 0, 8'h3C, 0);
    add(0, 1, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 1, 0, 1, 0, 8'h3C, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 0, 1, 0, 8'h3C, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 16'h000A, 0,  0, 0, 1, 8'h03, 0, 0, 0, 0, 8'h3C, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 0, 0, 1, 8'h0A, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 1, 8'h03, 0, 0, 0, 0, 8'h0A, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 1, 8'h03, 0, 0, 0, 0, 8'h0A, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 0, 0, 0, 8'h0A, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 0, 0, 1, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 1, 8'h03, 0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 0, 0, 0, 8'h00, 0);
    // ALU frame DD,02 -> FFFE sent as FE, FF; TX_BUSY stalls the send
    add(0, 1, 8'hDD, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 0, 1, 0, 8'h00, 0);
    add(0, 1, 8'h02, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 1, 2, 1, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1, 16'hFFFE, 0,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 2, 0, 1, 8'hFE, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'hFE, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'hFE, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'hFE, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 2, 0, 1, 8'hFF, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'hFF, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'hFF, 0);
    // unknown command, then a byte dropped during RD_WAIT
    add(0, 1, 8'h55, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'hFF, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'hFF, 0);
    add(0, 1, 8'hBB, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 1, 8'h03, 0, 2, 0, 0, 8'hFF, 0);
    add(0, 1, 8'h0A, 0, 8'h00, 0, 16'h0000, 0,  0, 1,10, 8'h03, 0, 2, 0, 0, 8'hFF, 0);
    add(0, 1, 8'h11, 0, 8'h00, 0, 16'h0000, 0,  0, 0,10, 8'h03, 0, 2, 0, 0, 8'hFF, 1);
    add(0, 0, 8'h00, 1, 8'h5A, 0, 16'h0000, 0,  0, 0,10, 8'h03, 0, 2, 0, 0, 8'hFF, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0,10, 8'h03, 0, 2, 0, 1, 8'h5A, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 1,  0, 0,10, 8'h03, 0, 2, 0, 0, 8'h5A, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0,10, 8'h03, 0, 2, 0, 0, 8'h5A, 0);
    // stray result strobes in IDLE are ignored
    add(0, 0, 8'h00, 1, 8'h77, 1, 16'h1234, 0,  0, 0,10, 8'h03, 0, 2, 0, 0, 8'h5A, 0);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0,10, 8'h03, 0, 2, 0, 0, 8'h5A, 0);
    // reset during OPB (with coincident RX_D_VLD) clears everything
    add(0, 1, 8'hCC, 0, 8'h00, 0, 16'h0000, 0,  0, 0,10, 8'h03, 0, 2, 1, 0, 8'h5A, 0);
    add(0, 1, 8'h44, 0, 8'h00, 0, 16'h0000, 0,  1, 0, 0, 8'h44, 0, 2, 1, 0, 8'h5A, 0);
    add(1, 1, 8'h55, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 8'h55, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 0,  0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);

    foreach (vq[i]) begin
      RST = vq[i].rst; RX_D_VLD = vq[i].rxv; RX_P_DATA = vq[i].rxd;
      RdData_Valid = vq[i].rdv; RdData = vq[i].rdd;
      ALU_OUT_VLD = vq[i].av; ALU_OUT = vq[i].ao; TX_BUSY = vq[i].busy;
      @(posedge CLK); #1;
      chk($sformatf("row%0d", i), outs(), vq[i].exp);
    end

`ifdef CMD_TIMEOUT_EN
    // AA then silence: error after exactly TMO idle cycles
    step(1'b1, 8'hAA);
    seen_err = 1'b0;
    for (int i = 0; i < int'(TMO) - 1; i++) begin
      step(1'b0, 8'h00);
      seen_err = seen_err | CMD_ERR;
    end
    chk("tmo_early", {29'd0, seen_err}, 30'd0);
    step(1'b0, 8'h00);
    chk("tmo_err", {29'd0, CMD_ERR}, 30'd1);
    step(1'b0, 8'h00);
    chk("tmo_err_clr", {29'd0, CMD_ERR}, 30'd0);
    step(1'b1, 8'hAA);
    step(1'b1, 8'h01);
    step(1'b1, 8'hFF);
    chk("tmo_wr_after", {17'd0, WrEn, Address, WrData}, {17'd0, 1'b1, 4'd1, 8'hFF});
    // ALU_FN abandoned: gate enable drops with the error
    step(1'b1, 8'hDD);
    chk("tmo_cg_on", {29'd0, CLK_GATE_EN}, 30'd1);
    for (int i = 0; i < int'(TMO) - 1; i++) step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("tmo_cg_off", {28'd0, CMD_ERR, CLK_GATE_EN}, {28'd0, 2'b10});
`else
    // partial frame waits indefinitely, then completes
    step(1'b1, 8'hAA);
    seen_err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 8'h00);
      seen_err = seen_err | CMD_ERR;
    end
    chk("wait_no_err", {29'd0, seen_err}, 30'd0);
    step(1'b1, 8'h01);
    step(1'b1, 8'hFF);
    chk("wait_wr_after", {17'd0, WrEn, Address, WrData}, {17'd0, 1'b1, 4'd1, 8'hFF});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
